// File: rtl/demux5to1_reg.sv
// Registered 1-to-5 demultiplexer with per-slot valid/ready handshakes.
// Invalid selects are accepted and dropped, and tracked by a sticky flag and a saturating count.
module demux5to1_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] a0,
  output logic [WIDTH-1:0] a1,
  output logic [WIDTH-1:0] a2,
  output logic [WIDTH-1:0] a3,
  output logic [WIDTH-1:0] a4,
  output logic [4:0]       out_valid,
  input  logic [4:0]       out_ready,
  output logic             sel_err,
  output logic [7:0]       drop_cnt,
  input  logic             err_clr
);

  logic [WIDTH-1:0] r_data [5];
  logic [4:0]       r_valid;
  logic             r_sel_err;
  logic [7:0]       r_drop_cnt;

  logic [4:0] w_sel_hot;
  logic       w_sel_ok;
  logic [4:0] w_slot_free;
  logic       w_in_ready;
  logic       w_xfer;
  logic       w_drop;
  logic [4:0] w_load;
  logic [4:0] w_take;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_sel_hot = 5'b00000;
    w_sel_ok  = 1'b1;
    case (in_sel)
      3'd0:    w_sel_hot = 5'b00001;
      3'd1:    w_sel_hot = 5'b00010;
      3'd2:    w_sel_hot = 5'b00100;
      3'd3:    w_sel_hot = 5'b01000;
      3'd4:    w_sel_hot = 5'b10000;
      default: w_sel_ok  = 1'b0;
    endcase
  end

  // A slot can accept when empty or when its consumer drains it this same cycle.
  assign w_slot_free = ~r_valid | out_ready;
  assign w_in_ready  = w_sel_ok ? |(w_sel_hot & w_slot_free) : 1'b1;
  assign w_xfer      = in_valid & w_in_ready;
  assign w_drop      = w_xfer & ~w_sel_ok;
  assign w_load      = w_sel_hot & {5{w_xfer}};
  assign w_take      = r_valid & out_ready;

  // NOTE: the data registers are reset too, because a0-a4 must read zero during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 5; i++) r_data[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (w_load[i]) r_data[i] <= in_data;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 5'b00000;
    end else begin
      r_valid <= w_load | (r_valid & ~w_take);
    end
  end

  // A clear coinciding with a drop leaves the drop counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err  <= 1'b0;
      r_drop_cnt <= 8'd0;
    end else if (err_clr) begin
      r_sel_err  <= w_drop;
      r_drop_cnt <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop) begin
      r_sel_err  <= 1'b1;
      if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign in_ready  = w_in_ready;
  assign a0        = r_data[0];
  assign a1        = r_data[1];
  assign a2        = r_data[2];
  assign a3        = r_data[3];
  assign a4        = r_data[4];
  assign out_valid = r_valid;
  assign sel_err   = r_sel_err;
  assign drop_cnt  = r_drop_cnt;

endmodule
